// File: rtl/c1541_track_ctrl_pkg.sv
// Shared definitions for the 1541 track controller: FSM states, zone tables, track mapping.
// Pure package, no timing of its own.
// No flow control; the functions are combinational helpers.
package c1541_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FLUSH_REQ,
    ST_FLUSH_WAIT,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_READY
  } state_t;

  // Per-zone sectors per track
  localparam logic [4:0] SECS_Z0 = 5'd21;
  localparam logic [4:0] SECS_Z1 = 5'd19;
  localparam logic [4:0] SECS_Z2 = 5'd18;
  localparam logic [4:0] SECS_Z3 = 5'd17;

  // First D64 sector index of each zone
  localparam logic [9:0] BASE_Z0 = 10'd0;
  localparam logic [9:0] BASE_Z1 = 10'd357;
  localparam logic [9:0] BASE_Z2 = 10'd490;
  localparam logic [9:0] BASE_Z3 = 10'd598;

  // First track of each zone
  localparam logic [5:0] START_Z0 = 6'd1;
  localparam logic [5:0] START_Z1 = 6'd18;
  localparam logic [5:0] START_Z2 = 6'd25;
  localparam logic [5:0] START_Z3 = 6'd31;
  localparam logic [5:0] TRACK_MAX = 6'd40;

  // Head positions outside 1..40 map onto the nearest real track
  function automatic logic [5:0] clamp_track(input logic [5:0] t);
    logic [5:0] r;
    r = t;
    if (t < START_Z0) r = START_Z0;
    else if (t > TRACK_MAX) r = TRACK_MAX;
    return r;
  endfunction

  function automatic logic [9:0] track_base(input logic [5:0] t_in);
    logic [5:0] t;
    logic [9:0] r;
    t = clamp_track(t_in);
    if (t < START_Z1)      r = BASE_Z0 + {4'd0, t - START_Z0} * {5'd0, SECS_Z0};
    else if (t < START_Z2) r = BASE_Z1 + {4'd0, t - START_Z1} * {5'd0, SECS_Z1};
    else if (t < START_Z3) r = BASE_Z2 + {4'd0, t - START_Z2} * {5'd0, SECS_Z2};
    else                   r = BASE_Z3 + {4'd0, t - START_Z3} * {5'd0, SECS_Z3};
    return r;
  endfunction

  function automatic logic [4:0] track_count(input logic [5:0] t_in);
    logic [5:0] t;
    logic [4:0] r;
    t = clamp_track(t_in);
    if (t < START_Z1)      r = SECS_Z0;
    else if (t < START_Z2) r = SECS_Z1;
    else if (t < START_Z3) r = SECS_Z2;
    else                   r = SECS_Z3;
    return r;
  endfunction

  // Index of the lowest set bit; 0 for an empty mask
  function automatic logic [4:0] first_set(input logic [20:0] m);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 20; i >= 0; i--) begin
      if (m[i]) r = i[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/c1541_track_ctrl_lba.sv
// Maps the head track to its D64 base sector index and sector count.
// One clk32 cycle latency, result follows the track input continuously.
// No backpressure; the consumer samples once the track has been stable.
module c1541_track_lba
  import c1541_pkg::*;
(
  input  logic       clk32,
  input  logic       reset_n,
  input  logic [5:0] track,
  output logic [9:0] base,
  output logic [4:0] count
);

  // Register the zone lookup so the adder/multiplier chain stays off the FSM path
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      base  <= 10'd0;
      count <= 5'd0;
    end else begin
      base  <= track_base(track);
      count <= track_count(track);
    end
  end

endmodule

// File: rtl/c1541_track_ctrl.sv
// Keeps one D64 track in the buffer: settles head moves, flushes dirty sectors, reloads.
// Requests go out one cycle after the decision; one sector per SD handshake.
// Waits on sd_ack for every sector; the GCR side only runs while ram_ready is high.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYC = 16'd32000
) (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic [5:0] track,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic       gcr_we,
  input  logic [4:0] gcr_sector,
  output logic       ram_ready,
  output logic [9:0] sd_lba,
  output logic       sd_rd,
  output logic       sd_wr,
  input  logic       sd_ack,
  output logic [4:0] buf_sector,
  output logic       busy
);

  state_t      state;
  logic [15:0] settle_cnt;
  logic [20:0] dirty;
  logic [20:0] dirty_rest;
  logic [5:0]  trk_q, loaded_trk, tgt_trk;
  logic        loaded_vld;
  logic [9:0]  lba_base, old_base, new_base;
  logic [4:0]  lba_count, old_count, new_count;
  logic        ack_q, ack_fall, mnt_pend, abort_pend;

  c1541_track_lba u_lba (
    .clk32   (clk32),
    .reset_n (reset_n),
    .track   (track),
    .base    (lba_base),
    .count   (lba_count)
  );

  assign ack_fall   = ack_q & ~sd_ack;
  assign dirty_rest = dirty & ~(21'd1 << buf_sector);
  assign ram_ready  = (state == ST_READY);
  assign busy       = (state == ST_FLUSH_REQ) || (state == ST_FLUSH_WAIT) ||
                      (state == ST_LOAD_REQ)  || (state == ST_LOAD_WAIT);

  // Track-buffer sequencer: settle, write back dirty sectors of the old track, load the new one
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;   settle_cnt <= 16'd0; dirty <= '0;
      trk_q <= 6'd0;      loaded_trk <= 6'd0;  tgt_trk <= 6'd0; loaded_vld <= 1'b0;
      old_base <= 10'd0;  new_base <= 10'd0;   old_count <= 5'd0; new_count <= 5'd0;
      ack_q <= 1'b0;      mnt_pend <= 1'b0;    abort_pend <= 1'b0;
      sd_rd <= 1'b0;      sd_wr <= 1'b0;       sd_lba <= 10'd0;  buf_sector <= 5'd0;
    end else begin
      ack_q <= sd_ack;
      trk_q <= track;
      // A new disk throws away unsaved edits and the buffered track
      if (img_mounted) begin
        dirty      <= '0;
        loaded_vld <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (img_mounted || (loaded_vld && track != loaded_trk)) begin
            state <= ST_SETTLE; settle_cnt <= 16'd0;
          end
        end
        ST_SETTLE: begin
          if (img_mounted || track != trk_q) begin
            settle_cnt <= 16'd0;
          end else if (settle_cnt == SETTLE_CYC - 16'd1) begin
            tgt_trk   <= track;
            new_base  <= lba_base;
            new_count <= lba_count;
            if (|dirty) begin
              state      <= ST_FLUSH_REQ;
              buf_sector <= first_set(dirty);
              sd_wr      <= 1'b1;
              sd_lba     <= old_base + {5'd0, first_set(dirty)};
            end else begin
              state      <= ST_LOAD_REQ;
              loaded_vld <= 1'b0;
              buf_sector <= 5'd0;
              sd_rd      <= 1'b1;
              sd_lba     <= lba_base;
            end
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        ST_FLUSH_REQ: begin
          if (sd_ack) begin
            sd_wr <= 1'b0; state <= ST_FLUSH_WAIT;
            if (img_mounted) mnt_pend <= 1'b1;
          end else if (img_mounted) begin
            sd_wr <= 1'b0; state <= ST_SETTLE; settle_cnt <= 16'd0;
          end
        end
        ST_FLUSH_WAIT: begin
          if (img_mounted) mnt_pend <= 1'b1;
          if (ack_fall) begin
            mnt_pend <= 1'b0;
            if (img_mounted || mnt_pend) begin
              state <= ST_SETTLE; settle_cnt <= 16'd0;
            end else begin
              dirty[buf_sector] <= 1'b0;
              if (|dirty_rest) begin
                state      <= ST_FLUSH_REQ;
                buf_sector <= first_set(dirty_rest);
                sd_wr      <= 1'b1;
                sd_lba     <= old_base + {5'd0, first_set(dirty_rest)};
              end else if (track != tgt_trk) begin
                // Head moved while we were writing: settle again on the new position
                state <= ST_SETTLE; settle_cnt <= 16'd0;
              end else begin
                state      <= ST_LOAD_REQ;
                loaded_vld <= 1'b0;
                buf_sector <= 5'd0;
                sd_rd      <= 1'b1;
                sd_lba     <= new_base;
              end
            end
          end
        end
        ST_LOAD_REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0; state <= ST_LOAD_WAIT;
            if (img_mounted) mnt_pend <= 1'b1;
            if (track != tgt_trk) abort_pend <= 1'b1;
          end else if (img_mounted || track != tgt_trk) begin
            sd_rd <= 1'b0; state <= ST_SETTLE; settle_cnt <= 16'd0;
          end
        end
        ST_LOAD_WAIT: begin
          if (img_mounted) mnt_pend <= 1'b1;
          if (track != tgt_trk) abort_pend <= 1'b1;
          if (ack_fall) begin
            mnt_pend   <= 1'b0;
            abort_pend <= 1'b0;
            if (img_mounted || mnt_pend || abort_pend || track != tgt_trk) begin
              state <= ST_SETTLE; settle_cnt <= 16'd0;
            end else if (buf_sector == new_count - 5'd1) begin
              state      <= ST_READY;
              loaded_trk <= tgt_trk;
              loaded_vld <= 1'b1;
              old_base   <= new_base;
              old_count  <= new_count;
            end else begin
              state      <= ST_LOAD_REQ;
              buf_sector <= buf_sector + 5'd1;
              sd_rd      <= 1'b1;
              sd_lba     <= new_base + {5'd0, buf_sector + 5'd1};
            end
          end
        end
        ST_READY: begin
          if (!img_mounted && gcr_we && !img_readonly && gcr_sector < old_count)
            dirty[gcr_sector] <= 1'b1;
          if (img_mounted || track != loaded_trk) begin
            state <= ST_SETTLE; settle_cnt <= 16'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed bench for the track controller with a simple SD host that acks every request.
module tb_c1541_track_ctrl;

  logic       clk32 = 1'b0;
  logic       reset_n;
  logic [5:0] track;
  logic       img_mounted, img_readonly, gcr_we, sd_ack;
  logic [4:0] gcr_sector;
  logic       ram_ready, sd_rd, sd_wr, busy;
  logic [9:0] sd_lba;
  logic [4:0] buf_sector;

  int n_assert = 0;
  int n_fail   = 0;

  bit         log_wr[$];
  logic [9:0] log_lba[$];

  c1541_track_ctrl #(.SETTLE_CYC(16'd8)) dut (
    .clk32        (clk32),
    .reset_n      (reset_n),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .gcr_we       (gcr_we),
    .gcr_sector   (gcr_sector),
    .ram_ready    (ram_ready),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .buf_sector   (buf_sector),
    .busy         (busy)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SD host: log each request, ack one cycle later, hold ack for three cycles
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk32);
      if (sd_rd || sd_wr) begin
        chk("rd_wr_exclusive", {31'd0, sd_rd & sd_wr}, 0);
        log_wr.push_back(sd_wr);
        log_lba.push_back(sd_lba);
        @(negedge clk32);
        sd_ack = 1'b1;
        @(negedge clk32);
        chk("req_drop_on_ack", {31'd0, sd_rd | sd_wr}, 0);
        repeat (2) @(negedge clk32);
        sd_ack = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_wr.delete();
    log_lba.delete();
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ram_ready && k < 5000) begin
      @(negedge clk32);
      k++;
    end
    chk(tag, {31'd0, ram_ready}, 1);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!(sd_rd || sd_wr) && k < 2000) begin
      @(negedge clk32);
      k++;
    end
    chk(tag, {31'd0, sd_rd | sd_wr}, 1);
  endtask

  task automatic check_log(input string tag, input int idx, input int n, input bit wr, input int lba0);
    for (int i = 0; i < n; i++) begin
      if (idx + i < log_lba.size()) begin
        chk({tag, "_op"}, {31'd0, log_wr[idx+i]}, {31'd0, wr});
        chk({tag, "_lba"}, {22'd0, log_lba[idx+i]}, lba0 + i);
      end
    end
  endtask

  task automatic mount_pulse();
    @(negedge clk32); img_mounted = 1'b1;
    @(negedge clk32); img_mounted = 1'b0;
  endtask

  task automatic gcr_write(input logic [4:0] s);
    @(negedge clk32); gcr_we = 1'b1; gcr_sector = s;
    @(negedge clk32); gcr_we = 1'b0;
  endtask

  task automatic move_to(input logic [5:0] t);
    @(negedge clk32); track = t;
    @(negedge clk32);
  endtask

  initial begin
    int k;
    reset_n = 1'b0; track = 6'd5; img_mounted = 1'b0; img_readonly = 1'b0;
    gcr_we = 1'b0; gcr_sector = 5'd0;
    repeat (3) @(negedge clk32);
    chk("rst_ram_ready", {31'd0, ram_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sd_rd", {31'd0, sd_rd}, 0);
    chk("rst_sd_wr", {31'd0, sd_wr}, 0);
    chk("rst_sd_lba", {22'd0, sd_lba}, 0);
    chk("rst_buf_sector", {27'd0, buf_sector}, 0);
    reset_n = 1'b1;

    // A track value alone must not start anything after reset
    repeat (20) @(negedge clk32);
    chk("idle_no_busy", {31'd0, busy}, 0);
    chk("idle_no_rd", {31'd0, sd_rd}, 0);

    // Mount on track 18: 19 reads 357..375
    clear_log();
    track = 6'd18;
    mount_pulse();
    wait_req("t18_req");
    chk("t18_busy_in_load", {31'd0, busy}, 1);
    chk("t18_not_ready_in_load", {31'd0, ram_ready}, 0);
    wait_ready("t18_ready");
    chk("t18_count", log_lba.size(), 19);
    check_log("t18", 0, 19, 1'b0, 357);
    chk("t18_busy_done", {31'd0, busy}, 0);

    // 18 -> 19 -> 18 inside the settle window: settle restarts from the last change
    clear_log();
    move_to(6'd19);
    @(negedge clk32);
    track = 6'd18;
    k = 0;
    while (!(sd_rd || sd_wr) && k < 50) begin
      @(negedge clk32);
      k++;
    end
    chk("toggle_no_early_req", {31'd0, k >= 8}, 1);
    chk("toggle_req_in_time", {31'd0, k <= 10}, 1);
    wait_ready("toggle_ready");
    chk("toggle_count", log_lba.size(), 19);
    check_log("toggle", 0, 19, 1'b0, 357);

    // Track 1, then dirty sectors 3 and 20 (21 is past the track end), then track 2
    move_to(6'd1);
    wait_ready("t1_ready");
    clear_log();
    gcr_write(5'd3);
    gcr_write(5'd20);
    gcr_write(5'd21);
    move_to(6'd2);
    wait_req("t2_first_req");
    chk("t2_busy_in_flush", {31'd0, busy}, 1);
    chk("t2_first_slot", {27'd0, buf_sector}, 3);
    wait_ready("t2_ready");
    chk("t2_count", log_lba.size(), 23);
    check_log("t2_wr3", 0, 1, 1'b1, 3);
    check_log("t2_wr20", 1, 1, 1'b1, 20);
    check_log("t2_rd", 2, 21, 1'b0, 21);

    // Write-protected image: edits never become writes
    clear_log();
    img_readonly = 1'b1;
    gcr_write(5'd5);
    move_to(6'd3);
    wait_ready("t3_ready");
    img_readonly = 1'b0;
    chk("t3_count", log_lba.size(), 21);
    check_log("t3_rd", 0, 21, 1'b0, 42);

    // Head moves during the 4th read of track 35: that read finishes, then track 10 loads fully
    clear_log();
    move_to(6'd35);
    k = 0;
    while (!(log_lba.size() == 4 && sd_ack) && k < 2000) begin
      @(negedge clk32);
      k++;
    end
    @(negedge clk32);
    track = 6'd10;
    @(negedge clk32);
    wait_ready("t10_ready");
    chk("t10_count", log_lba.size(), 25);
    check_log("t35_partial", 0, 4, 1'b0, 666);
    check_log("t10_rd", 4, 21, 1'b0, 189);

    // Mount during the first flush write: that write completes, the rest are dropped
    clear_log();
    gcr_write(5'd7);
    gcr_write(5'd2);
    gcr_write(5'd15);
    move_to(6'd11);
    k = 0;
    while (!(log_lba.size() == 1 && sd_ack) && k < 2000) begin
      @(negedge clk32);
      k++;
    end
    mount_pulse();
    wait_ready("mnt_ready");
    chk("mnt_count", log_lba.size(), 22);
    check_log("mnt_wr", 0, 1, 1'b1, 191);
    check_log("mnt_rd", 1, 21, 1'b0, 210);
    clear_log();
    move_to(6'd12);
    wait_ready("t12_ready");
    chk("t12_count_no_wr", log_lba.size(), 21);
    check_log("t12_rd", 0, 21, 1'b0, 231);

    // Clamping: track 0 behaves as track 1, track 40 has base 751 and 17 sectors
    clear_log();
    move_to(6'd0);
    wait_ready("t0_ready");
    chk("t0_count", log_lba.size(), 21);
    check_log("t0_rd", 0, 21, 1'b0, 0);
    clear_log();
    move_to(6'd40);
    wait_ready("t40_ready");
    chk("t40_count", log_lba.size(), 17);
    check_log("t40_rd", 0, 17, 1'b0, 751);

    // 17-sector track: slot 16 is writable, slot 17 is not
    clear_log();
    gcr_write(5'd17);
    gcr_write(5'd16);
    move_to(6'd39);
    wait_ready("t39_ready");
    chk("t39_count", log_lba.size(), 18);
    check_log("t39_wr", 0, 1, 1'b1, 767);
    check_log("t39_rd", 1, 17, 1'b0, 734);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/c1541_track_ctrl.md
C1541_TRACK_CTRL -- requirements
Module: c1541_track_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16'd32000, meaning clk32 cycles the track number must stay stable (1 ms) before a load starts.
REQ-002 SHALL have ports:
- clk32  in  1  system clock, 32 MHz
- reset_n  in  1  reset, asynchronous, active-low
- track  in  6  requested track from the head stepper, 1..40
- img_mounted  in  1  one-cycle pulse: a new image was inserted
- img_readonly  in  1  image is write-protected
- gcr_we  in  1  track-RAM write strobe from the GCR datapath
- gcr_sector  in  5  sector currently addressed by the GCR datapath
- ram_ready  out  1  track buffer valid; GCR datapath may run
- sd_lba  out  10  D64 256-byte sector index, 0..767
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  host acknowledge, high while a transfer runs
- buf_sector  out  5  track-buffer slot used by the SD transfer
- busy  out  1  flush or load in progress

Function
REQ-003 SHALL run the FSM states IDLE, SETTLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT, READY.
REQ-004 SHALL move IDLE->SETTLE on img_mounted, or when the track input differs from the loaded track.
REQ-005 SHALL hold a 16-bit settle counter in SETTLE, reloaded to 0 whenever track changes; when it reaches SETTLE_CYC-1 the FSM SHALL go to FLUSH_REQ if any dirty bit is set, else to LOAD_REQ.
REQ-006 SHALL compute the track base LBA as:
- t<18: (t-1)*21
- t<25: 357+(t-18)*19
- t<31: 490+(t-25)*18
- else: 598+(t-31)*17
REQ-007 SHALL clamp track 0 to 1 and any track above 40 to 40 before computing the base LBA.
REQ-008 SHALL use sector counts of 21/19/18/17 for the same four ranges.
REQ-009 SHALL set sd_lba = base + buf_sector, registered, valid whenever sd_rd or sd_wr is high.
REQ-010 SHALL follow the SD handshake:
- the request is raised in the *_REQ state
- the request is dropped on the first cycle sd_ack=1 and the FSM moves to *_WAIT
- the transfer is complete on the sd_ack falling edge
- sd_rd and sd_wr are never high together
REQ-011 SHALL scan the dirty mask during FLUSH from lowest to highest set bit, writing only dirty sectors and clearing each bit on its sd_ack fall; when the mask is empty the FSM SHALL go to LOAD_REQ.
REQ-012 SHALL compute the FLUSH LBA from the latched old track, never from the live track input.
REQ-013 SHALL load every sector 0..count-1 of the new track in LOAD, then latch the loaded track and go to READY.
REQ-014 SHALL drive ram_ready=1 only in READY; busy=1 in FLUSH_* and LOAD_*.
REQ-015 SHALL set dirty[gcr_sector] on a gcr_we cycle only when in READY, img_readonly=0, and gcr_sector is below the sector count.
REQ-016 SHALL ignore gcr_we in all other states.
REQ-017 SHALL go READY->SETTLE when track changes, keeping the dirty mask for the flush.
REQ-018 SHALL, on a track change during LOAD_WAIT, finish the current transfer, then go to SETTLE with no flush.
REQ-019 SHALL ignore track changes during FLUSH; on completion it SHALL re-evaluate in SETTLE.
REQ-020 SHALL, on img_mounted in any state:
- clear the dirty mask with no flush
- invalidate the loaded track
- go to SETTLE once no transfer is in flight; a transfer in WAIT completes first
REQ-021 SHALL make the buf_sector width sufficient: the maximum slot is 20.

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force:
- FSM=IDLE; dirty=0; settle counter=0; loaded track invalid
- ram_ready=0, busy=0, sd_rd=0, sd_wr=0, sd_lba=0, buf_sector=0
REQ-023 SHALL leave IDLE after reset only on img_mounted, never on a track value alone.

Structure
REQ-024 SHALL place in package c1541_pkg: the state enum, per-zone sector counts (21/19/18/17), zone base LBAs (0/357/490/598), zone start tracks (1/18/25/31), and the track-to-base/count functions.
REQ-025 SHALL have one sub-module, c1541_track_lba: a registered track-to-{base,count} mapper with 1-cycle latency, whose result the FSM consumes in SETTLE.

Verification
REQ-026 SHALL cover these directed scenarios:
- Mount pulse with track=18, SETTLE_CYC=8 -> 19 reads with LBA 357..375 in order -> ram_ready=1.
- In READY on track 1, gcr_we with sectors 3 and 20, then track->2 -> writes to LBA 3 and 20 only -> reads of LBA 21..41 -> ready.
- img_readonly=1, gcr_we on sector 5, track change -> no sd_wr issued.
- Track toggles 18->19->18 within the settle window -> no transfer starts; the counter restarts on each change.
- Track change during the 4th load read on track 35 -> that read completes; new settle; full reload of the new track.
- img_mounted during FLUSH_WAIT -> the current write finishes, no further writes, the dirty mask is 0, then a reload.
- Track 0 -> LBA 0..20; track 40 -> base 751, 17 sectors.
